// File: rtl/score_bcd_keeper.sv
// score_bcd_keeper: BCD score accumulator and high-score latch for the snake game.
// Event inputs (game_start, point, game_over) are single-cycle pulses sampled on
// the rising edge of clk; there is no back-pressure, and every pulse is consumed
// (or dropped) in the cycle it is presented. Priority: game_start > game_over > point.
module score_bcd_keeper #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  game_start,
    input  logic                  point,
    input  logic [3:0]            pts,
    input  logic                  game_over,
    input  logic                  show_high,
    output logic [4*DIGITS-1:0]   disp,
    output logic                  playing,
    output logic                  new_high,
    output logic                  saturated
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        OVER    = 2'd2
    } state_t;

    state_t       state, state_next;
    logic [W-1:0] score, score_next;
    logic [W-1:0] high, high_next;
    logic         new_high_next;
    logic         saturated_next;

    logic [3:0]   addend;
    logic [W-1:0] bcd_sum;
    logic         bcd_carry;

    // Ripple BCD adder: score + clamped pts, decimal carry between digits.
    always_comb begin
        logic [4:0] dsum;
        logic [4:0] carry;
        addend  = (pts > 4'd9) ? 4'd9 : pts;
        bcd_sum = '0;
        carry   = 5'd0;
        dsum    = 5'd0;
        for (int i = 0; i < DIGITS; i++) begin
            dsum = {1'b0, score[i*4 +: 4]} + ((i == 0) ? {1'b0, addend} : 5'd0) + carry;
            if (dsum > 5'd9) begin
                dsum  = dsum - 5'd10;
                carry = 5'd1;
            end else begin
                carry = 5'd0;
            end
            bcd_sum[i*4 +: 4] = dsum[3:0];
        end
        bcd_carry = carry[0];
    end

    // Next-state and next-register logic; defaults hold everything.
    // Valid BCD digits order like binary nibbles, so an unsigned compare of the
    // packed vectors is the MSD-first lexicographic comparison.
    always_comb begin
        state_next     = state;
        score_next     = score;
        high_next      = high;
        new_high_next  = new_high;
        saturated_next = saturated;
        if (game_start) begin
            state_next     = PLAYING;
            score_next     = '0;
            new_high_next  = 1'b0;
            saturated_next = 1'b0;
        end else if (state == PLAYING) begin
            if (game_over) begin
                state_next = OVER;
                if (score > high) begin
                    high_next     = score;
                    new_high_next = 1'b1;
                end
            end else if (point) begin
                if (bcd_carry) begin
                    score_next     = ALL_NINES;
                    saturated_next = 1'b1;
                end else begin
                    score_next = bcd_sum;
                end
            end
        end
    end

    // State and score registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            score     <= '0;
            high      <= '0;
            new_high  <= 1'b0;
            saturated <= 1'b0;
        end else begin
            state     <= state_next;
            score     <= score_next;
            high      <= high_next;
            new_high  <= new_high_next;
            saturated <= saturated_next;
        end
    end

    // Display register: samples the currently selected register each cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            disp <= '0;
        end else begin
            disp <= show_high ? high : score;
        end
    end

    assign playing = (state == PLAYING);

endmodule

// File: tb/tb_score_bcd_keeper.sv
// tb_score_bcd_keeper: directed test-plan scenarios plus random pulses, checked
// against an integer-arithmetic model of the score keeper.
module tb_score_bcd_keeper;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 9999;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic         game_start = 1'b0;
    logic         point = 1'b0;
    logic [3:0]   pts = 4'd0;
    logic         game_over = 1'b0;
    logic         show_high = 1'b0;
    logic [W-1:0] disp;
    logic         playing;
    logic         new_high;
    logic         saturated;

    score_bcd_keeper #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .game_start (game_start),
        .point      (point),
        .pts        (pts),
        .game_over  (game_over),
        .show_high  (show_high),
        .disp       (disp),
        .playing    (playing),
        .new_high   (new_high),
        .saturated  (saturated)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    // Reference model in plain integers.
    int score_m = 0;
    int high_m = 0;
    bit in_game_m = 0;
    bit new_high_m = 0;
    bit sat_m = 0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        score_m = 0;
        high_m = 0;
        in_game_m = 0;
        new_high_m = 0;
        sat_m = 0;
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    // Called at a negedge: drives one cycle of inputs, updates the model, checks.
    task automatic cycle(input bit gs, input bit pt, input int p, input bit go, input bit sh);
        int a;
        game_start = gs;
        point      = pt;
        pts        = 4'(p);
        game_over  = go;
        show_high  = sh;
        exp_q.push_back(sh ? to_bcd(high_m) : to_bcd(score_m));
        if (gs) begin
            in_game_m  = 1;
            score_m    = 0;
            new_high_m = 0;
            sat_m      = 0;
        end else if (go && in_game_m) begin
            in_game_m = 0;
            if (score_m > high_m) begin
                high_m     = score_m;
                new_high_m = 1;
            end
        end else if (pt && in_game_m) begin
            a = (p > 9) ? 9 : p;
            if (score_m + a > MAXV) begin
                score_m = MAXV;
                sat_m   = 1;
            end else begin
                score_m = score_m + a;
            end
        end
        @(posedge clk);
        @(negedge clk);
        game_start = 1'b0;
        point      = 1'b0;
        game_over  = 1'b0;
        check("disp", disp, exp_q.pop_front());
        check("playing", playing, in_game_m);
        check("new_high", new_high, new_high_m);
        check("saturated", saturated, sat_m);
    endtask

    task automatic idle(input bit sh);
        cycle(0, 0, 0, 0, sh);
    endtask

    task automatic add_to(input int target);
        while (score_m < target) begin
            cycle(0, 1, (target - score_m > 9) ? 9 : target - score_m, 0, 0);
        end
    endtask

    // Watchdog: the run is bounded even if something stalls.
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #1;
        check("rst_disp", disp, 0);
        check("rst_playing", playing, 0);
        check("rst_new_high", new_high, 0);
        check("rst_saturated", saturated, 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // 12 points of 1
        cycle(1, 0, 0, 0, 0);
        repeat (12) cycle(0, 1, 1, 0, 0);
        idle(0);
        check("tp_012", disp, 16'h0012);
        check("tp_012_playing", playing, 1);
        check("tp_012_sat", saturated, 0);

        // decimal carry across two digits, then clamp of 12 to 9
        cycle(1, 0, 0, 0, 0);
        add_to(98);
        cycle(0, 1, 5, 0, 0);
        idle(0);
        check("tp_0103", disp, 16'h0103);
        cycle(0, 1, 12, 0, 0);
        idle(0);
        check("tp_0112", disp, 16'h0112);
        cycle(0, 1, 0, 0, 0);
        idle(0);
        check("tp_pts0", disp, 16'h0112);

        // saturation
        cycle(1, 0, 0, 0, 0);
        add_to(9995);
        cycle(0, 1, 7, 0, 0);
        idle(0);
        check("tp_sat_disp", disp, 16'h9999);
        check("tp_sat_flag", saturated, 1);
        cycle(0, 1, 1, 0, 0);
        idle(0);
        check("tp_sat_hold", disp, 16'h9999);
        cycle(1, 0, 0, 0, 0);
        idle(0);
        check("tp_sat_clear_disp", disp, 16'h0000);
        check("tp_sat_clear_flag", saturated, 0);

        // high-score handling
        cycle(1, 0, 0, 0, 0);
        add_to(45);
        cycle(0, 0, 0, 1, 0);
        idle(1);
        check("tp_high45", disp, 16'h0045);
        check("tp_high45_new", new_high, 1);
        cycle(1, 0, 0, 0, 0);
        add_to(45);
        cycle(0, 0, 0, 1, 0);
        idle(1);
        check("tp_equal_new", new_high, 0);
        check("tp_equal_high", disp, 16'h0045);
        cycle(0, 0, 0, 1, 1);
        idle(1);
        check("tp_over_go_ignored", new_high, 0);
        cycle(1, 0, 0, 0, 0);
        add_to(100);
        cycle(0, 0, 0, 1, 0);
        idle(1);
        check("tp_high100", disp, 16'h0100);
        check("tp_high100_new", new_high, 1);

        // same-cycle priority
        cycle(1, 0, 0, 0, 0);
        add_to(10);
        cycle(0, 1, 3, 1, 0);
        idle(0);
        check("tp_go_drops_point", disp, 16'h0010);
        check("tp_go_over", playing, 0);
        cycle(0, 1, 5, 0, 0);
        idle(0);
        check("tp_over_point_ignored", disp, 16'h0010);
        cycle(1, 1, 3, 0, 0);
        idle(0);
        check("tp_start_drops_point", disp, 16'h0000);
        check("tp_start_playing", playing, 1);

        // asynchronous reset mid-game
        add_to(500);
        cycle(0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0);
        add_to(321);
        idle(0);
        check("tp_pre_reset", disp, 16'h0321);
        #2;
        resetn = 1'b0;
        #1;
        check("async_disp", disp, 0);
        check("async_playing", playing, 0);
        check("async_new_high", new_high, 0);
        check("async_saturated", saturated, 0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        check("post_reset_high", disp, 16'h0000);
        cycle(0, 1, 4, 0, 0);
        idle(0);
        check("post_reset_idle_point", disp, 16'h0000);

        // randomized pulses against the model
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 1) == 1),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 3) == 0));
        end
        idle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
